// File: rtl/processor_pkg.sv
// Shared types and default widths for the memory stage of the processor pipeline.
package processor_pkg;

  localparam int unsigned DefaultDataW   = 16;
  localparam int unsigned DefaultRdW     = 4;
  localparam int unsigned DefaultTimeout = 15;

  typedef enum logic {
    StIdle,
    StWait
  } mem_state_e;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts WAIT cycles of an outstanding memory access; expired flags the final allowed cycle.
module mem_timeout_counter
  import processor_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CntW-1:0] count_q, count_d;

  // count_q holds the number of WAIT cycles already completed, so the current
  // cycle is number count_q + 1.
  assign expired = (32'(count_q) + 32'd1) >= TIMEOUT;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/memory_cycle.sv
// Memory stage: retires ALU results directly, issues loads/stores and waits for ack or timeout.
module memory_cycle
  import processor_pkg::*;
#(
  parameter int unsigned DATA_W  = DefaultDataW,
  parameter int unsigned RD_W    = DefaultRdW,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] bout,
  input  logic [RD_W-1:0]   rdout,
  input  logic              memread,
  input  logic              memwrite,
  input  logic              regwrite,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic [DATA_W-1:0] wb_data,
  output logic [RD_W-1:0]   wb_rd,
  output logic              fwd_en,
  output logic [DATA_W-1:0] fwd_data,
  output logic [RD_W-1:0]   fwd_rd,
  output logic              err
);

  mem_state_e state_q, state_d;

  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              rw_q, rw_d;

  logic              wb_valid_q, wb_valid_d;
  logic              wb_rw_q, wb_rw_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
  logic              err_q, err_d;

  logic              in_wait;
  logic              expired;

  assign in_wait = (state_q == StWait);

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_wait),
    .enable  (in_wait),
    .expired (expired)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    rw_d       = rw_q;
    wb_valid_d = 1'b0;
    wb_rw_d    = wb_rw_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    err_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (!memread && !memwrite) begin
            wb_valid_d = 1'b1;
            wb_rw_d    = regwrite;
            wb_data_d  = aluout;
            wb_rd_d    = rdout;
          end else if ((memread ^ memwrite) && !aluout[0]) begin
            state_d = StWait;
            req_d   = 1'b1;
            we_d    = memwrite;
            addr_d  = aluout;
            wdata_d = bout;
            rd_d    = rdout;
            rw_d    = regwrite;
          end else begin
            // Misaligned or contradictory controls: retire as a faulted no-op.
            wb_valid_d = 1'b1;
            wb_rw_d    = 1'b0;
            wb_data_d  = aluout;
            wb_rd_d    = rdout;
            err_d      = 1'b1;
          end
        end
      end
      StWait: begin
        // Ack is checked before expiry so a last-cycle ack still completes cleanly.
        if (mem_ack) begin
          state_d    = StIdle;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          if (we_q) begin
            wb_data_d = addr_q;
            wb_rw_d   = 1'b0;
          end else begin
            wb_data_d = mem_rdata;
            wb_rw_d   = rw_q;
          end
        end else if (expired) begin
          state_d    = StIdle;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_rw_d    = 1'b0;
          wb_data_d  = addr_q;
          wb_rd_d    = rd_q;
          err_d      = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      rw_q       <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      rw_q       <= rw_d;
      wb_valid_q <= wb_valid_d;
      wb_rw_q    <= wb_rw_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      err_q      <= err_d;
    end
  end

  assign stall       = in_wait;
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_regwrite = wb_rw_q;
  assign wb_data     = wb_data_q;
  assign wb_rd       = wb_rd_q;
  assign err         = err_q;

  assign fwd_en   = wb_valid_q & wb_rw_q & (wb_rd_q != '0);
  assign fwd_data = wb_data_q;
  assign fwd_rd   = wb_rd_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: ALU retire, load/store, faults, timeout and reset in WAIT.
module tb_memory_cycle;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] aluout;
  logic [15:0] bout;
  logic [3:0]  rdout;
  logic        memread;
  logic        memwrite;
  logic        regwrite;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        wb_valid;
  logic        wb_regwrite;
  logic [15:0] wb_data;
  logic [3:0]  wb_rd;
  logic        fwd_en;
  logic [15:0] fwd_data;
  logic [3:0]  fwd_rd;
  logic        err;

  int n_checks = 0;
  int n_bad    = 0;

  memory_cycle u_dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .aluout      (aluout),
    .bout        (bout),
    .rdout       (rdout),
    .memread     (memread),
    .memwrite    (memwrite),
    .regwrite    (regwrite),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .wb_valid    (wb_valid),
    .wb_regwrite (wb_regwrite),
    .wb_data     (wb_data),
    .wb_rd       (wb_rd),
    .fwd_en      (fwd_en),
    .fwd_data    (fwd_data),
    .fwd_rd      (fwd_rd),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] rd, input logic mr, input logic mw, input logic rw);
    in_valid = v;
    aluout   = a;
    bout     = b;
    rdout    = rd;
    memread  = mr;
    memwrite = mw;
    regwrite = rw;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);

    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_req", 32'(mem_req), 32'd0);
    check_eq("rst_wbv", 32'(wb_valid), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_wbdata", 32'(wb_data), 32'd0);
    rst = 1'b1;

    // ALU op followed back-to-back by a second ALU op to r0
    @(negedge clk);
    drive(1'b1, 16'h1234, 16'h0, 4'd3, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_eq("alu_wbv", 32'(wb_valid), 32'd1);
    check_eq("alu_data", 32'(wb_data), 32'h1234);
    check_eq("alu_rd", 32'(wb_rd), 32'd3);
    check_eq("alu_rw", 32'(wb_regwrite), 32'd1);
    check_eq("alu_fwd_en", 32'(fwd_en), 32'd1);
    check_eq("alu_fwd_data", 32'(fwd_data), 32'h1234);
    check_eq("alu_fwd_rd", 32'(fwd_rd), 32'd3);
    drive(1'b1, 16'h5678, 16'h0, 4'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_eq("b2b_wbv", 32'(wb_valid), 32'd1);
    check_eq("b2b_data", 32'(wb_data), 32'h5678);
    check_eq("b2b_fwd_r0", 32'(fwd_en), 32'd0);
    idle_inputs();
    @(negedge clk);
    check_eq("idle_wbv", 32'(wb_valid), 32'd0);
    check_eq("idle_err", 32'(err), 32'd0);

    // Ack in IDLE is ignored
    mem_ack = 1'b1;
    @(negedge clk);
    check_eq("ack_idle_wbv", 32'(wb_valid), 32'd0);
    check_eq("ack_idle_stall", 32'(stall), 32'd0);
    mem_ack = 1'b0;

    // Load at 0x0040, ack in the 3rd WAIT cycle
    drive(1'b1, 16'h0040, 16'h0, 4'd5, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check_eq("ld_req", 32'(mem_req), 32'd1);
    check_eq("ld_we", 32'(mem_we), 32'd0);
    check_eq("ld_addr", 32'(mem_addr), 32'h0040);
    check_eq("ld_wbv0", 32'(wb_valid), 32'd0);
    check_eq("ld_stall1", 32'(stall), 32'd1);
    drive(1'b1, 16'h9998, 16'h0, 4'd9, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_eq("ld_stall2", 32'(stall), 32'd1);
    check_eq("ld_wbv_ignored", 32'(wb_valid), 32'd0);
    @(negedge clk);
    check_eq("ld_stall3", 32'(stall), 32'd1);
    check_eq("ld_addr_hold", 32'(mem_addr), 32'h0040);
    drive(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    mem_ack   = 1'b1;
    mem_rdata = 16'hBEEF;
    @(negedge clk);
    mem_ack = 1'b0;
    check_eq("ld_done_stall", 32'(stall), 32'd0);
    check_eq("ld_done_req", 32'(mem_req), 32'd0);
    check_eq("ld_wbv", 32'(wb_valid), 32'd1);
    check_eq("ld_data", 32'(wb_data), 32'hBEEF);
    check_eq("ld_rw", 32'(wb_regwrite), 32'd1);
    check_eq("ld_rd", 32'(wb_rd), 32'd5);
    check_eq("ld_err", 32'(err), 32'd0);
    @(negedge clk);
    check_eq("ld_wbv_pulse", 32'(wb_valid), 32'd0);

    // Store at 0x0042 with data 0x00FF, inputs change while waiting
    drive(1'b1, 16'h0042, 16'h00FF, 4'd7, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check_eq("st_req", 32'(mem_req), 32'd1);
    check_eq("st_we", 32'(mem_we), 32'd1);
    check_eq("st_wdata", 32'(mem_wdata), 32'h00FF);
    drive(1'b1, 16'h0100, 16'h1111, 4'd2, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check_eq("st_wdata_hold", 32'(mem_wdata), 32'h00FF);
    check_eq("st_addr_hold", 32'(mem_addr), 32'h0042);
    check_eq("st_we_hold", 32'(mem_we), 32'd1);
    idle_inputs();
    mem_ack   = 1'b1;
    mem_rdata = 16'hAAAA;
    @(negedge clk);
    mem_ack = 1'b0;
    check_eq("st_wbv", 32'(wb_valid), 32'd1);
    check_eq("st_rw", 32'(wb_regwrite), 32'd0);
    check_eq("st_data", 32'(wb_data), 32'h0042);
    check_eq("st_fwd", 32'(fwd_en), 32'd0);

    // Misaligned load and contradictory controls
    drive(1'b1, 16'h0041, 16'h0, 4'd2, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check_eq("mis_req", 32'(mem_req), 32'd0);
    check_eq("mis_stall", 32'(stall), 32'd0);
    check_eq("mis_err", 32'(err), 32'd1);
    check_eq("mis_wbv", 32'(wb_valid), 32'd1);
    check_eq("mis_rw", 32'(wb_regwrite), 32'd0);
    drive(1'b1, 16'h0044, 16'h0, 4'd2, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check_eq("both_req", 32'(mem_req), 32'd0);
    check_eq("both_err", 32'(err), 32'd1);
    idle_inputs();
    @(negedge clk);
    check_eq("err_pulse", 32'(err), 32'd0);

    // Load with no ack: request held 15 WAIT cycles, then err
    drive(1'b1, 16'h0060, 16'h0, 4'd4, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    idle_inputs();
    for (int i = 1; i < 15; i++) @(negedge clk);
    check_eq("to_req15", 32'(mem_req), 32'd1);
    check_eq("to_err15", 32'(err), 32'd0);
    @(negedge clk);
    check_eq("to_req_drop", 32'(mem_req), 32'd0);
    check_eq("to_err", 32'(err), 32'd1);
    check_eq("to_wbv", 32'(wb_valid), 32'd1);
    check_eq("to_rw", 32'(wb_regwrite), 32'd0);
    check_eq("to_stall", 32'(stall), 32'd0);
    @(negedge clk);
    check_eq("to_err_pulse", 32'(err), 32'd0);

    // Ack in the 15th WAIT cycle wins over the timeout
    drive(1'b1, 16'h0062, 16'h0, 4'd6, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    idle_inputs();
    for (int i = 1; i < 15; i++) @(negedge clk);
    check_eq("ack15_stall", 32'(stall), 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 16'h1357;
    @(negedge clk);
    mem_ack = 1'b0;
    check_eq("ack15_err", 32'(err), 32'd0);
    check_eq("ack15_wbv", 32'(wb_valid), 32'd1);
    check_eq("ack15_data", 32'(wb_data), 32'h1357);
    check_eq("ack15_rw", 32'(wb_regwrite), 32'd1);

    // Reset asserted mid-WAIT abandons the access immediately
    drive(1'b1, 16'h0070, 16'h0, 4'd8, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    idle_inputs();
    check_eq("rw_req_before", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("rw_req_async", 32'(mem_req), 32'd0);
    check_eq("rw_stall_async", 32'(stall), 32'd0);
    @(negedge clk);
    check_eq("rw_wbv", 32'(wb_valid), 32'd0);
    check_eq("rw_err", 32'(err), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rw_wbv_after", 32'(wb_valid), 32'd0);
    check_eq("rw_req_after", 32'(mem_req), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
